// File: rtl/frame_write_controller.sv
// Packs a received byte stream into BYTES_PER_WORD-wide words and issues
// one memory write per completed word at sequential frame addresses.
module frame_write_controller #(
  parameter int BYTES_PER_WORD = 3,
  parameter int DEPTH          = 196608,
  parameter int ADDR_W         = 18,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYC    = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_byte_received,
  input  logic                        i_rx_data_ready,
  input  logic                        i_clear,
  output logic                        o_en,
  output logic                        o_we,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [8*BYTES_PER_WORD-1:0] o_din,
  output logic [1:0]                  o_status,
  output logic [1:0]                  o_byte_counter,
  output logic                        o_frame_done,
  output logic                        o_timeout_err
);

  localparam int              W         = 8 * BYTES_PER_WORD;
  localparam logic [1:0]      LAST_IDX  = 2'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam bit              TO_EN     = (TIMEOUT_CYC > 0);
  localparam int              TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   IDLE_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [W-1:0]      r_din;
  logic [W-1:0]      r_word;
  logic [1:0]        r_byte_counter;
  logic [TW-1:0]     r_idle;
  logic              r_timeout_err;

  logic              w_accept;
  logic              w_complete;
  logic              w_last_addr;
  logic              w_timeout;
  logic [W-1:0]      w_word_shift;

  // A byte arriving together with clear belongs to the abandoned frame.
  assign w_accept    = i_rx_data_ready & ~i_clear;
  assign w_complete  = w_accept && (r_byte_counter == LAST_IDX);
  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_timeout   = TO_EN && (r_byte_counter != 2'd0) && !i_rx_data_ready
                       && (r_idle == IDLE_LAST);

  generate
    if (BYTES_PER_WORD == 1) begin : g_single
      assign w_word_shift = i_byte_received;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign w_word_shift = {r_word[W-9:0], i_byte_received};
    end else begin : g_lsb
      assign w_word_shift = {i_byte_received, r_word[W-1:8]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_complete)    w_state_next = S_WRITE;
          else if (w_accept) w_state_next = S_COLLECT;
        end
        S_COLLECT: begin
          if (w_complete) w_state_next = S_WRITE;
        end
        S_WRITE: begin
          if (w_complete)       w_state_next = S_WRITE;
          else if (w_last_addr) w_state_next = S_IDLE;
          else                  w_state_next = S_COLLECT;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_din          <= '0;
      r_word         <= '0;
      r_byte_counter <= 2'd0;
      r_idle         <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timeout_err <= 1'b0;
      if (i_clear) begin
        r_addr         <= '0;
        r_word         <= '0;
        r_byte_counter <= 2'd0;
        r_idle         <= '0;
      end else begin
        if (r_state == S_WRITE) begin
          r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
        end
        if (w_complete) begin
          r_din          <= w_word_shift;
          r_word         <= '0;
          r_byte_counter <= 2'd0;
          r_idle         <= '0;
        end else if (w_accept) begin
          r_word         <= w_word_shift;
          r_byte_counter <= r_byte_counter + 2'd1;
          r_idle         <= '0;
        end else if (w_timeout) begin
          r_word         <= '0;
          r_byte_counter <= 2'd0;
          r_idle         <= '0;
          r_timeout_err  <= 1'b1;
        end else if (r_byte_counter != 2'd0) begin
          r_idle <= r_idle + 1'b1;
        end else begin
          r_idle <= '0;
        end
      end
    end
  end

  assign o_en           = (r_state == S_WRITE);
  assign o_we           = (r_state == S_WRITE);
  assign o_addr         = r_addr;
  assign o_din          = r_din;
  assign o_status       = r_state;
  assign o_byte_counter = r_byte_counter;
  assign o_frame_done   = (r_state == S_WRITE) && w_last_addr;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_frame_write_controller.sv
// Directed vector bench: one small-frame instance with timeout checked every
// cycle, plus default and LSB-first instances spot-checked on shared stimulus.
module tb_frame_write_controller;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       rdy;
  logic       clr;

  logic        a_en, a_we, a_fd, a_te;
  logic [17:0] a_addr;
  logic [23:0] a_din;
  logic [1:0]  a_st, a_cnt;

  logic        b_en, b_we, b_fd, b_te;
  logic [17:0] b_addr;
  logic [23:0] b_din;
  logic [1:0]  b_st, b_cnt;

  logic        c_en, c_we, c_fd, c_te;
  logic [17:0] c_addr;
  logic [23:0] c_din;
  logic [1:0]  c_st, c_cnt;

  int checks;
  int failures;

  frame_write_controller #(
    .BYTES_PER_WORD(3), .DEPTH(4), .ADDR_W(18), .MSB_FIRST(1), .TIMEOUT_CYC(8)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_byte_received(byte_in), .i_rx_data_ready(rdy),
    .i_clear(clr), .o_en(a_en), .o_we(a_we), .o_addr(a_addr), .o_din(a_din),
    .o_status(a_st), .o_byte_counter(a_cnt), .o_frame_done(a_fd), .o_timeout_err(a_te)
  );

  frame_write_controller u_b (
    .i_clk(clk), .i_rst(rst), .i_byte_received(byte_in), .i_rx_data_ready(rdy),
    .i_clear(clr), .o_en(b_en), .o_we(b_we), .o_addr(b_addr), .o_din(b_din),
    .o_status(b_st), .o_byte_counter(b_cnt), .o_frame_done(b_fd), .o_timeout_err(b_te)
  );

  frame_write_controller #(.MSB_FIRST(0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_byte_received(byte_in), .i_rx_data_ready(rdy),
    .i_clear(clr), .o_en(c_en), .o_we(c_we), .o_addr(c_addr), .o_din(c_din),
    .o_status(c_st), .o_byte_counter(c_cnt), .o_frame_done(c_fd), .o_timeout_err(c_te)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [7:0]  b;
    logic        clr;
    logic        en;
    logic [17:0] addr;
    logic [23:0] din;
    logic [1:0]  st;
    logic [1:0]  cnt;
    logic        fd;
    logic        te;
  } vec_t;

  localparam int NV = 44;
  vec_t vecs[NV];

  function automatic vec_t mk(logic rn, logic r, logic [7:0] b, logic c, logic en,
                              logic [17:0] ad, logic [23:0] d, logic [1:0] st,
                              logic [1:0] cnt, logic fd, logic te);
    vec_t v;
    v.rst_n = rn; v.rdy = r; v.b = b; v.clr = c; v.en = en; v.addr = ad;
    v.din = d; v.st = st; v.cnt = cnt; v.fd = fd; v.te = te;
    return v;
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", nm, k, act, exp);
    end
  endtask

  int          wr_cnt;
  int          wr_cyc[2];
  logic [17:0] wr_addr[2];
  logic [23:0] wr_din[2];

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; rdy = 1'b0; byte_in = 8'h00; clr = 1'b0;

    //              rn rdy byte  clr en addr din       st cnt fd te
    vecs[0]  = mk(0, 0, 8'h00, 0, 0, 0, 24'h000000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'hAA, 0, 0, 0, 24'h000000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 8'h11, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
    vecs[3]  = mk(1, 1, 8'h22, 0, 0, 0, 24'h000000, 1, 2, 0, 0);
    vecs[4]  = mk(1, 1, 8'h33, 0, 1, 0, 24'h112233, 2, 0, 0, 0);
    vecs[5]  = mk(1, 0, 8'h00, 0, 0, 1, 24'h112233, 1, 0, 0, 0);
    vecs[6]  = mk(1, 1, 8'h44, 0, 0, 1, 24'h112233, 1, 1, 0, 0);
    vecs[7]  = mk(1, 1, 8'h55, 0, 0, 1, 24'h112233, 1, 2, 0, 0);
    vecs[8]  = mk(1, 1, 8'h66, 0, 1, 1, 24'h445566, 2, 0, 0, 0);
    vecs[9]  = mk(1, 1, 8'h77, 0, 0, 2, 24'h445566, 1, 1, 0, 0);
    vecs[10] = mk(1, 1, 8'h88, 0, 0, 2, 24'h445566, 1, 2, 0, 0);
    vecs[11] = mk(1, 1, 8'h99, 0, 1, 2, 24'h778899, 2, 0, 0, 0);
    vecs[12] = mk(1, 1, 8'hAB, 0, 0, 3, 24'h778899, 1, 1, 0, 0);
    vecs[13] = mk(1, 1, 8'hCD, 0, 0, 3, 24'h778899, 1, 2, 0, 0);
    vecs[14] = mk(1, 1, 8'hEF, 0, 1, 3, 24'hABCDEF, 2, 0, 1, 0);
    vecs[15] = mk(1, 0, 8'h00, 0, 0, 0, 24'hABCDEF, 0, 0, 0, 0);
    vecs[16] = mk(1, 1, 8'h01, 0, 0, 0, 24'hABCDEF, 1, 1, 0, 0);
    vecs[17] = mk(1, 1, 8'h02, 0, 0, 0, 24'hABCDEF, 1, 2, 0, 0);
    for (int i = 18; i <= 24; i++)
      vecs[i] = mk(1, 0, 8'h00, 0, 0, 0, 24'hABCDEF, 1, 2, 0, 0);
    vecs[25] = mk(1, 0, 8'h00, 0, 0, 0, 24'hABCDEF, 1, 0, 0, 1);
    vecs[26] = mk(1, 0, 8'h00, 0, 0, 0, 24'hABCDEF, 1, 0, 0, 0);
    vecs[27] = mk(1, 1, 8'h03, 0, 0, 0, 24'hABCDEF, 1, 1, 0, 0);
    vecs[28] = mk(1, 1, 8'h04, 0, 0, 0, 24'hABCDEF, 1, 2, 0, 0);
    vecs[29] = mk(1, 1, 8'h05, 0, 1, 0, 24'h030405, 2, 0, 0, 0);
    vecs[30] = mk(1, 0, 8'h00, 0, 0, 1, 24'h030405, 1, 0, 0, 0);
    vecs[31] = mk(1, 1, 8'h06, 0, 0, 1, 24'h030405, 1, 1, 0, 0);
    vecs[32] = mk(1, 1, 8'h07, 1, 0, 0, 24'h030405, 0, 0, 0, 0);
    vecs[33] = mk(1, 1, 8'h08, 0, 0, 0, 24'h030405, 1, 1, 0, 0);
    vecs[34] = mk(1, 1, 8'h09, 0, 0, 0, 24'h030405, 1, 2, 0, 0);
    vecs[35] = mk(1, 1, 8'h0A, 0, 1, 0, 24'h08090A, 2, 0, 0, 0);
    vecs[36] = mk(1, 0, 8'h00, 1, 0, 0, 24'h08090A, 0, 0, 0, 0);
    vecs[37] = mk(1, 1, 8'h0B, 0, 0, 0, 24'h08090A, 1, 1, 0, 0);
    vecs[38] = mk(1, 1, 8'h0C, 0, 0, 0, 24'h08090A, 1, 2, 0, 0);
    vecs[39] = mk(0, 1, 8'hBB, 0, 0, 0, 24'h000000, 0, 0, 0, 0);
    vecs[40] = mk(1, 1, 8'h0D, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
    vecs[41] = mk(1, 1, 8'h0E, 0, 0, 0, 24'h000000, 1, 2, 0, 0);
    vecs[42] = mk(1, 1, 8'h0F, 0, 1, 0, 24'h0D0E0F, 2, 0, 0, 0);
    vecs[43] = mk(1, 0, 8'h00, 0, 0, 1, 24'h0D0E0F, 1, 0, 0, 0);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst = vecs[k].rst_n; rdy = vecs[k].rdy; byte_in = vecs[k].b; clr = vecs[k].clr;
      @(posedge clk);
      #1;
      check("en",          k, a_en,   vecs[k].en);
      check("we",          k, a_we,   vecs[k].en);
      check("addr",        k, a_addr, vecs[k].addr);
      check("din",         k, a_din,  vecs[k].din);
      check("status",      k, a_st,   vecs[k].st);
      check("byte_counter", k, a_cnt, vecs[k].cnt);
      check("frame_done",  k, a_fd,   vecs[k].fd);
      check("timeout_err", k, a_te,   vecs[k].te);
      if (k == 4) begin
        check("dflt_en",   k, b_en,   1);
        check("dflt_addr", k, b_addr, 0);
        check("dflt_din",  k, b_din,  24'h112233);
        check("lsb_din",   k, c_din,  24'h332211);
      end
      if (k == 8) begin
        check("dflt_addr", k, b_addr, 1);
        check("dflt_din",  k, b_din,  24'h445566);
        check("lsb_din",   k, c_din,  24'h665544);
      end
      if (k == 14) check("dflt_frame_done", k, b_fd, 0);
      if (k == 15) check("dflt_addr_nowrap", k, b_addr, 4);
      $display("vec %0d rdy=%0b byte=%02h clr=%0b -> st=%0d cnt=%0d addr=%0d en=%0b din=%06h",
               k, rdy, byte_in, clr, a_st, a_cnt, a_addr, a_en, a_din);
    end

    // Back-to-back strobes: six bytes on consecutive cycles.
    wr_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = (c < 6); byte_in = 8'(8'h10 * (c + 1)); clr = 1'b0;
      @(posedge clk);
      #1;
      if (a_en) begin
        if (wr_cnt < 2) begin
          wr_cyc[wr_cnt] = c; wr_addr[wr_cnt] = a_addr; wr_din[wr_cnt] = a_din;
        end
        wr_cnt++;
      end
    end
    @(negedge clk);
    rdy = 1'b0;
    check("b2b_writes", 100, wr_cnt, 2);
    if (wr_cnt >= 2) begin
      check("b2b_cyc0",  100, wr_cyc[0], 2);
      check("b2b_gap",   100, wr_cyc[1] - wr_cyc[0], 3);
      check("b2b_addr0", 100, wr_addr[0], 1);
      check("b2b_din0",  100, wr_din[0], 24'h102030);
      check("b2b_addr1", 100, wr_addr[1], 2);
      check("b2b_din1",  100, wr_din[1], 24'h405060);
    end
    check("b2b_final_addr", 100, a_addr, 3);
    check("b2b_final_cnt",  100, a_cnt, 0);
    $display("b2b writes=%0d final st=%0d addr=%0d", wr_cnt, a_st, a_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
